fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queued fetched instructions; SHALL be a power of two, 2 to 16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset; all state SHALL clear while reset=0.
REQ-005 Port stall, input, 1, downstream decode register not accepting this cycle.
REQ-006 Port redirect_valid, input, 1, branch/jump flush request.
REQ-007 Port redirect_pc, input, 32, new fetch address, valid with redirect_valid.
REQ-008 Port imem_req, output, 1, instruction memory read request.
REQ-009 Port imem_addr, output, 32, word address of request, valid with imem_req.
REQ-010 Port imem_rvalid, input, 1, read data valid, exactly one cycle after the matching imem_req.
REQ-011 Port imem_rdata, input, 32, instruction word, valid with imem_rvalid.
REQ-012 Port valid_out, output, 1, pc_out/instruction_out hold a fetched instruction.
REQ-013 Port pc_out, output, 32, address of presented instruction.
REQ-014 Port instruction_out, output, 32, presented instruction word.

Function
REQ-015 Storage: circular buffer of DEPTH {pc, instruction} entries; read pointer, write pointer, count 0..DEPTH.
REQ-016 Internal fetch_pc register; one outstanding-request flag; one epoch bit tagging the outstanding request.
REQ-017 imem_req SHALL be 1 when count + outstanding < DEPTH and redirect_valid=0; imem_addr = fetch_pc.
REQ-018 On each issued request fetch_pc SHALL increment by 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-019 imem_rvalid with matching epoch SHALL push {issued address, imem_rdata} at write pointer; mismatched epoch SHALL be dropped.
REQ-020 valid_out SHALL equal (count != 0); pc_out/instruction_out SHALL be the head entry, combinational from storage.
REQ-021 When count=0: valid_out=0, pc_out=32'h0, instruction_out=32'h0000_0013 (NOP).
REQ-022 Pop occurs when valid_out=1 and stall=0; read pointer advances.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; queue never overflows by REQ-017 credit rule.
REQ-024 stall=1 SHALL hold head stable; fetching continues until credits exhausted.
REQ-025 redirect_valid=1: next edge count=0, pointers=0, fetch_pc=redirect_pc, epoch toggled; same-cycle push and pop SHALL be discarded.
REQ-026 First request for the redirect target SHALL issue the cycle after redirect; target visible on valid_out two cycles later (3 cycles after redirect).
REQ-027 Latency: request cycle N, response cycle N+1, entry visible on outputs cycle N+2; no bypass path.
REQ-028 Full (count=DEPTH) with stall=0: pop and refill sustain one instruction per cycle once primed.
REQ-029 redirect_pc low two bits SHALL be forced to 0 on load.

Reset
REQ-030 While reset=0: count=0, pointers=0, outstanding=0, epoch=0, fetch_pc=RESET_PC, imem_req=0, valid_out=0, pc_out=0, instruction_out=NOP.
REQ-031 Reset asserted mid-operation SHALL discard queue contents and any in-flight response immediately.
REQ-032 First imem_req SHALL assert in the first cycle after reset deasserts.

Verification
REQ-033 Reset release, stall=0, memory returns addr-derived words -> valid_out at cycle 2, pc_out 0,4,8,... one per cycle.
REQ-034 stall=1 held 10 cycles -> queue fills to DEPTH=4, imem_req drops, head pc_out stays 0; release -> 4 queued plus further in order, no gap or duplicate.
REQ-035 redirect_valid with redirect_pc=32'h100 while a response is in flight -> stale response dropped, next valid_out shows pc_out=32'h100 three cycles later.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 Assert reset with queue full -> valid_out=0, instruction_out=32'h0000_0013 in same cycle; restart from RESET_PC.
REQ-038 Simultaneous redirect and pop at full queue -> count 0 next cycle, no old entry presented afterward.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory, decode and the branch unit.
// The master side belongs to the fetch queue; the slave side belongs to its environment.
interface fetch_queue_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;

  modport master (
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata,
    output valid_out,
    output pc_out,
    output instruction_out
  );

  modport slave (
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata,
    input  valid_out,
    input  pc_out,
    input  instruction_out
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited prefetch into a circular buffer of {pc, instruction}.
// Redirects flush the buffer and use an epoch bit to drop any response issued before the flush.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         reset,
  fetch_queue_if.master bus
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0]     NOP     = 32'h0000_0013;

  logic [31:0]      pc_mem  [DEPTH];
  logic [31:0]      ins_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] in_use;
  logic [31:0]      fetch_pc;
  logic [31:0]      issued_pc;
  logic             outstanding;
  logic             out_epoch;
  logic             epoch;
  logic             issue;
  logic             push;
  logic             pop;
  logic             has_head;

  // An outstanding request already owns a slot, so it is charged against the credit limit.
  always_comb begin
    in_use   = count + CNT_W'(outstanding);
    has_head = (count != '0);
    issue    = reset && !bus.redirect_valid && (in_use < DEPTH_C);
    push     = bus.imem_rvalid && outstanding && (out_epoch == epoch) && !bus.redirect_valid;
    pop      = has_head && !bus.stall && !bus.redirect_valid;
  end

  assign bus.imem_req        = issue;
  assign bus.imem_addr       = fetch_pc;
  assign bus.valid_out       = has_head;
  assign bus.pc_out          = has_head ? pc_mem[rd_ptr]  : 32'h0;
  assign bus.instruction_out = has_head ? ins_mem[rd_ptr] : NOP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= 32'h0;
        ins_mem[i] <= NOP;
      end
    end else if (push) begin
      pc_mem[wr_ptr]  <= issued_pc;
      ins_mem[wr_ptr] <= bus.imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Memory answers exactly one cycle after a request, so the outstanding flag simply follows issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      issued_pc   <= 32'h0;
      outstanding <= 1'b0;
      out_epoch   <= 1'b0;
      epoch       <= 1'b0;
    end else if (bus.redirect_valid) begin
      fetch_pc    <= {bus.redirect_pc[31:2], 2'b00};
      outstanding <= 1'b0;
      epoch       <= ~epoch;
    end else begin
      outstanding <= issue;
      if (issue) begin
        fetch_pc  <= fetch_pc + 32'd4;
        issued_pc <= fetch_pc;
        out_epoch <= epoch;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a memory model answers every request one cycle later and a
// scoreboard of expected {pc, instruction} pairs is compared against every instruction the queue hands off.
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC   = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst2 = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb [$];
  logic [63:0] sb_entry;
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] pend_addr = 32'h0;
  logic        mem_pending = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic        pend2 = 1'b0;
  logic [31:0] addr2 = 32'h0;

  fetch_queue_if bus ();
  fetch_queue_if bus2 ();

  fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.master)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk   (clk),
    .reset (rst2),
    .bus   (bus2.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic stall, input logic redir, input logic [31:0] target);
    @(posedge clk);
    #1;
    bus.stall          = stall;
    bus.redirect_valid = redir;
    bus.redirect_pc    = target;
  endtask

  // Instruction memory for the main instance: answers the address seen in the request cycle.
  always @(posedge clk) begin
    #1;
    bus.imem_rvalid = mem_pending;
    bus.imem_rdata  = mem_pending ? mem_word(mem_addr) : 32'h0;
  end

  always @(posedge clk) begin
    #1;
    bus2.imem_rvalid = pend2;
    bus2.imem_rdata  = pend2 ? mem_word(addr2) : 32'h0;
  end

  always @(negedge clk) begin
    pend2 = rst2 ? bus2.imem_req : 1'b0;
    addr2 = bus2.imem_addr;
  end

  // Scoreboard monitor: pops are checked before this cycle's response is queued, so a bypass shows up.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      exp_fetch   = RESET_PC;
      mem_pending = 1'b0;
    end else if (bus.redirect_valid) begin
      check_output("req_during_redirect", 32'(bus.imem_req), 32'h0);
      sb.delete();
      exp_fetch   = {bus.redirect_pc[31:2], 2'b00};
      mem_pending = 1'b0;
    end else begin
      if (bus.valid_out && !bus.stall) begin
        if (sb.size() == 0) begin
          check_output("sb_underflow", 32'h0, 32'h1);
        end else begin
          sb_entry = sb.pop_front();
          check_output("pop_pc", bus.pc_out, sb_entry[63:32]);
          check_output("pop_instr", bus.instruction_out, sb_entry[31:0]);
        end
      end
      if (bus.imem_rvalid) begin
        sb.push_back({pend_addr, mem_word(pend_addr)});
      end
      mem_pending = bus.imem_req;
      if (bus.imem_req) begin
        check_output("imem_addr", bus.imem_addr, exp_fetch);
        pend_addr = exp_fetch;
        mem_addr  = bus.imem_addr;
        exp_fetch = exp_fetch + 32'd4;
      end
    end
  end

  initial begin
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus2.stall          = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_valid", 32'(bus.valid_out), 32'h0);
    check_output("rst_pc", bus.pc_out, 32'h0);
    check_output("rst_instr", bus.instruction_out, NOP);
    check_output("rst_req", 32'(bus.imem_req), 32'h0);

    // Streaming from reset: first entry visible two cycles after the first request.
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_output("c0_req", 32'(bus.imem_req), 32'h1);
    check_output("c0_valid", 32'(bus.valid_out), 32'h0);
    @(negedge clk);
    check_output("c1_valid", 32'(bus.valid_out), 32'h0);
    @(negedge clk);
    check_output("c2_valid", 32'(bus.valid_out), 32'h1);
    check_output("c2_pc", bus.pc_out, RESET_PC);
    repeat (8) @(negedge clk);

    // Stall from reset: queue fills, requests stop, head holds.
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.stall = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check_output("stall_valid", 32'(bus.valid_out), 32'h1);
        check_output("stall_head", bus.pc_out, RESET_PC);
      end
    end
    check_output("stall_req_off", 32'(bus.imem_req), 32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_output("drain_no_gap", 32'(bus.valid_out), 32'h1);
    end

    // Redirect while a response is in flight.
    apply_stimulus(1'b0, 1'b1, 32'h0000_0100);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("redir_r1_valid", 32'(bus.valid_out), 32'h0);
    @(negedge clk);
    check_output("redir_r2_valid", 32'(bus.valid_out), 32'h0);
    @(negedge clk);
    check_output("redir_r3_valid", 32'(bus.valid_out), 32'h1);
    check_output("redir_r3_pc", bus.pc_out, 32'h0000_0100);
    repeat (6) @(negedge clk);

    // Redirect together with a pop at a full queue; target has low bits set.
    apply_stimulus(1'b1, 1'b0, 32'h0);
    repeat (8) @(negedge clk);
    check_output("full_before_redir", 32'(bus.valid_out), 32'h1);
    apply_stimulus(1'b0, 1'b1, 32'h0000_01F3);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("full_redir_r1_valid", 32'(bus.valid_out), 32'h0);
    @(negedge clk);
    check_output("full_redir_r2_valid", 32'(bus.valid_out), 32'h0);
    @(negedge clk);
    check_output("full_redir_r3_pc", bus.pc_out, 32'h0000_01F0);
    check_output("full_redir_r3_instr", bus.instruction_out, mem_word(32'h0000_01F0));
    repeat (6) @(negedge clk);

    // Asynchronous reset with a full queue clears outputs immediately.
    apply_stimulus(1'b1, 1'b0, 32'h0);
    repeat (8) @(posedge clk);
    #2;
    check_output("full_before_rst", 32'(bus.valid_out), 32'h1);
    #1 rst = 1'b0;
    #1;
    check_output("async_rst_valid", 32'(bus.valid_out), 32'h0);
    check_output("async_rst_instr", bus.instruction_out, NOP);
    check_output("async_rst_pc", bus.pc_out, 32'h0);
    check_output("async_rst_req", 32'(bus.imem_req), 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.stall = 1'b0;
    @(negedge clk);
    check_output("restart_req", 32'(bus.imem_req), 32'h1);
    check_output("restart_addr", bus.imem_addr, RESET_PC);
    repeat (6) @(negedge clk);

    // Address wrap from a high reset vector on the second instance.
    @(posedge clk);
    #1 rst2 = 1'b1;
    repeat (3) @(negedge clk);
    check_output("wrap_pc0", bus2.pc_out, 32'hFFFF_FFF8);
    check_output("wrap_instr0", bus2.instruction_out, mem_word(32'hFFFF_FFF8));
    @(negedge clk);
    check_output("wrap_pc1", bus2.pc_out, 32'hFFFF_FFFC);
    @(negedge clk);
    check_output("wrap_pc2", bus2.pc_out, 32'h0000_0000);
    check_output("wrap_instr2", bus2.instruction_out, mem_word(32'h0000_0000));
    check_output("wrap_valid", 32'(bus2.valid_out), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
